// File: rtl/rr_prio_enc.sv
// Purpose: reduces a 2**I_LEN request vector to one winning index plus one-hot grant, rotating or fixed base.
// Latency: 1 clock from req sampled to registered result; one grant per clock while out_ready is high.
// Backpressure: out_valid & !out_ready stalls the stage, holding all outputs and ignoring req until it drains.
module rr_prio_enc #(
    parameter int I_LEN = 3,
    parameter bit RR    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [(1<<I_LEN)-1:0] req,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [I_LEN-1:0]      out_idx,
    output logic [(1<<I_LEN)-1:0] out_onehot
);

    localparam int N = 1 << I_LEN;

    logic             accept;
    logic             load;
    logic [I_LEN-1:0] ptr;
    logic [I_LEN-1:0] next_after_idx;
    logic [I_LEN-1:0] base;
    logic [2*N-1:0]   req_dbl;
    logic [2*N-1:0]   req_shift;
    logic [N-1:0]     req_rot;
    logic [I_LEN-1:0] win_off;
    logic [I_LEN-1:0] winner;
    logic [N-1:0]     win_onehot;
    logic             any_req;

    assign accept         = out_valid & out_ready;
    assign load           = ~out_valid | out_ready;
    assign next_after_idx = out_idx + I_LEN'(1);
    assign any_req        = |req;

    // The base follows the grant being accepted this cycle, so a back-to-back reload is already fair.
    always_comb begin
        base = '0;
        if (RR) begin
            base = accept ? next_after_idx : ptr;
        end
    end

    // Rotate so the base lands at bit 0; the lowest set bit then gives the offset from the base.
    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> base;
    assign req_rot   = req_shift[N-1:0];

    always_comb begin
        win_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = I_LEN'(i);
            end
        end
    end

    assign winner = base + win_off;

    always_comb begin
        win_onehot         = '0;
        win_onehot[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
        end else if (load) begin
            if (any_req) begin
                out_valid  <= 1'b1;
                out_idx    <= winner;
                out_onehot <= win_onehot;
            end else begin
                out_valid  <= 1'b0;
                out_onehot <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (RR && accept) begin
            ptr <= next_after_idx;
        end
    end

endmodule

// File: tb/tb_rr_prio_enc.sv
// Purpose: checks rr_prio_enc (RR=1 and RR=0 instances, N=8) against a scan-based reference model.
// Latency: model advances on each rising edge; outputs compared every falling edge.
// Backpressure: out_ready is driven by directed scenarios and then randomised.
module tb_rr_prio_enc;

    localparam int I_LEN = 3;
    localparam int N     = 1 << I_LEN;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic             out_ready = 1'b1;
    logic             v1, v0;
    logic [I_LEN-1:0] idx1, idx0;
    logic [N-1:0]     oh1, oh0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_prio_enc #(.I_LEN(I_LEN), .RR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .out_valid(v1), .out_idx(idx1), .out_onehot(oh1)
    );

    rr_prio_enc #(.I_LEN(I_LEN), .RR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .out_valid(v0), .out_idx(idx0), .out_onehot(oh0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state is (valid, idx, ptr); next grant found by a linear modulo scan.
    int  m_v[2], m_i[2], m_p[2];

    task automatic model_step(input int k, input bit rr);
        int  base;
        int  win;
        bit  found;
        bit  acc;
        acc = (m_v[k] != 0) && out_ready;
        if (m_v[k] == 0 || out_ready) begin
            base  = acc ? (m_i[k] + 1) % N : m_p[k];
            if (!rr) base = 0;
            found = 1'b0;
            win   = 0;
            for (int s = 0; s < N; s++) begin
                if (!found && req[(base + s) % N]) begin
                    found = 1'b1;
                    win   = (base + s) % N;
                end
            end
            if (rr && acc) m_p[k] = (m_i[k] + 1) % N;
            if (found) begin
                m_v[k] = 1;
                m_i[k] = win;
            end else begin
                m_v[k] = 0;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_v[k] = 0;
                m_i[k] = 0;
                m_p[k] = 0;
            end
        end else begin
            model_step(0, 1'b1);
            model_step(1, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("rr_valid",  64'(v1),  64'(m_v[0]));
            check("rr_idx",    64'(idx1), 64'(m_i[0]));
            check("rr_onehot", 64'(oh1), m_v[0] != 0 ? (64'd1 << m_i[0]) : 64'd0);
            check("fx_valid",  64'(v0),  64'(m_v[1]));
            check("fx_idx",    64'(idx0), 64'(m_i[1]));
            check("fx_onehot", 64'(oh0), m_v[1] != 0 ? (64'd1 << m_i[1]) : 64'd0);
        end
    end

    task automatic reset_pulse();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    int e3[6] = '{0, 2, 7, 0, 2, 7};

    initial begin
        // Reset values while held in reset
        repeat (2) @(negedge clk);
        check("rst_valid",  64'(v1),   64'd0);
        check("rst_idx",    64'(idx1), 64'd0);
        check("rst_onehot", 64'(oh1),  64'd0);
        check("rst0_valid", 64'(v0),   64'd0);
        #1 rst_n = 1'b1;

        // Async reset mid-cycle, then first grant uses ptr=0
        req = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        check("t1_valid_before", 64'(v1), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_valid",  64'(v1),   64'd0);
        check("t1_async_idx",    64'(idx1), 64'd0);
        check("t1_async_onehot", 64'(oh1),  64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        req = 8'h24;
        @(negedge clk);
        check("t1_first_idx", 64'(idx1), 64'd2);

        // Round-robin over 8'b1000_0101
        reset_pulse();
        req = 8'h85;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t3_rr_seq",   64'(idx1), 64'(e3[i]));
            check("t3_rr_valid", 64'(v1),   64'd1);
            check("t3_fixed",    64'(idx0), 64'd0);
        end

        // Fixed priority holds lowest index
        #1 req = 8'hA4;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_fx_idx",    64'(idx0), 64'd2);
            check("t2_fx_onehot", 64'(oh0),  64'h04);
        end

        // Backpressure: grant held while req changes
        reset_pulse();
        req = 8'h24;
        @(negedge clk);
        check("t4_idx", 64'(idx1), 64'd2);
        #1 out_ready = 1'b0;
        req = 8'h80;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_idx",   64'(idx1), 64'd2);
            check("t4_stall_valid", 64'(v1),   64'd1);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("t4_after_idx", 64'(idx1), 64'd7);

        // Wrap past N-1
        reset_pulse();
        req = 8'h40;
        @(negedge clk);
        check("t5_idx6", 64'(idx1), 64'd6);
        #1 req = 8'h41;
        @(negedge clk);
        check("t5_wrap_idx", 64'(idx1), 64'd0);
        @(negedge clk);
        check("t5_next_idx", 64'(idx1), 64'd6);

        // Idle keeps ptr; then new requests
        #1 req = 8'h00;
        @(negedge clk);
        check("t6_idle_valid",  64'(v1),  64'd0);
        check("t6_idle_onehot", 64'(oh1), 64'd0);
        @(negedge clk);
        #1 req = 8'h81;
        @(negedge clk);
        check("t6_ptr_kept", 64'(idx1), 64'd7);
        #1 req = 8'h00;
        @(negedge clk);
        #1 req = 8'h10;
        @(negedge clk);
        check("t6_idx4",    64'(idx1), 64'd4);
        check("t6_onehot4", 64'(oh1),  64'h10);

        // Randomised traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse();
            end else begin
                @(negedge clk);
                #1;
            end
            case ($urandom_range(0, 3))
                0:       req = '0;
                1:       req = N'(1) << $urandom_range(0, N - 1);
                default: req = N'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
